// File: rtl/joy_dir_arbiter.sv
// ---------------------------------------------------------------------------
// joy_dir_arbiter
//
// Multi-channel joystick direction conditioner. It sits between the
// keyboard/joystick merge logic and the core's input ports. Each player
// channel goes through these stages:
//   1. two-flop synchroniser (s1 -> s2)
//   2. optional 90-degree clockwise remap (only with JOY_ARB_ROTATE_EN)
//   3. per-bit debounce, clocked by ce (bypassed when DEB_CYCLES == 0)
//   4. opposing-direction cancel (up+down -> none, left+right -> none)
//   5. arbitration, chosen per channel by mode:
//        00 passthrough of the debounced bits
//        01 4-way, last pressed wins
//        10 4-way, sticky (first pressed held until released)
//        11 8-way (diagonals kept, opposites cancelled)
//
// Optional feature macro: JOY_ARB_ROTATE_EN
//   Defined   : rotate[i] remaps channel i before debounce
//               (up<-left, right<-up, down<-right, left<-down).
//   Undefined : rotate is ignored.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   ce       in   debounce tick enable
//   mode     in   [2i+1:2i] arbitration mode of channel i
//   rotate   in   [i] 90-degree CW remap of channel i
//   indir    in   [4i+3:4i] raw {up,down,left,right}, active-high
//   outdir   out  [4i+3:4i] conditioned directions, registered
//   changed  out  [i] one-clk pulse, one clk after outdir of channel i moves
//
// Handshake: there is no valid/ready pair. A changed[i] pulse marks that
// outdir[i] took a new value on the previous clock; outdir[i] is valid on
// every clock after reset.
//
// Per-channel arbitration state lives in the packed struct g_ch[i].r_arb
// {state, dir} so checkers can bind to it directly.
// ---------------------------------------------------------------------------
module joy_dir_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int DEB_CYCLES = 0,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]     rotate,
    input  logic [4*CHANNELS-1:0]   indir,
    output logic [4*CHANNELS-1:0]   outdir,
    output logic [CHANNELS-1:0]     changed
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        state_t     state;
        logic [3:0] dir;
    } arb_t;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_LAST   = 2'b01;
    localparam logic [1:0] MODE_STICKY = 2'b10;
    localparam logic [1:0] MODE_8WAY   = 2'b11;

    // One-hot pick with priority up > down > left > right.
    function automatic logic [3:0] pri(input logic [3:0] x);
        logic [3:0] y;
        y = 4'b0000;
        if (x[3])      y = 4'b1000;
        else if (x[2]) y = 4'b0100;
        else if (x[1]) y = 4'b0010;
        else if (x[0]) y = 4'b0001;
        return y;
    endfunction

    // Opposing directions held together mean "neither".
    function automatic logic [3:0] cancel(input logic [3:0] x);
        logic [3:0] y;
        y = x;
        if (x[3] && x[2]) y[3:2] = 2'b00;
        if (x[1] && x[0]) y[1:0] = 2'b00;
        return y;
    endfunction

`ifdef JOY_ARB_ROTATE_EN
    // 90-degree clockwise remap: up<-left, down<-right, left<-down, right<-up.
    function automatic logic [3:0] rot_cw(input logic [3:0] x);
        return {x[1], x[0], x[2], x[3]};
    endfunction
`else
    logic w_unused_rotate;
    assign w_unused_rotate = ^rotate;
`endif

    generate
        if (DEB_CYCLES == 0) begin : g_ce_unused
            logic w_unused_ce;
            assign w_unused_ce = ce;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [1:0] w_mode;
            logic [3:0] r_s1;
            logic [3:0] r_s2;
            logic [3:0] w_s2m;
            logic [3:0] w_stable;
            logic [3:0] w_c;
            logic [3:0] r_c_d;
            logic [3:0] w_new;
            logic [3:0] w_pri_c;
            logic [3:0] w_pri_new;
            logic [1:0] r_mode_d;
            logic [3:0] r_outdir;
            logic [3:0] r_prev;
            logic       r_changed;
            arb_t       r_arb;

            assign w_mode = mode[2*gi +: 2];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1 <= 4'b0000;
                    r_s2 <= 4'b0000;
                end else begin
                    r_s1 <= indir[4*gi +: 4];
                    r_s2 <= r_s1;
                end
            end

`ifdef JOY_ARB_ROTATE_EN
            assign w_s2m = rotate[gi] ? rot_cw(r_s2) : r_s2;
`else
            assign w_s2m = r_s2;
`endif

            if (DEB_CYCLES == 0) begin : g_nodeb
                assign w_stable = w_s2m;
            end else begin : g_deb
                localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
                logic [3:0]       r_stable;
                logic [CNT_W-1:0] r_cnt [4];

                // Any return to the accepted level restarts the count, so a
                // glitch shorter than DEB_CYCLES ce ticks never gets through.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        r_stable <= 4'b0000;
                        for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (w_s2m[b] == r_stable[b]) begin
                                r_cnt[b] <= '0;
                            end else if (ce) begin
                                if (r_cnt[b] == DEB_LAST) begin
                                    r_stable[b] <= w_s2m[b];
                                    r_cnt[b]    <= '0;
                                end else begin
                                    r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                                end
                            end
                        end
                    end
                end

                assign w_stable = r_stable;
            end

            assign w_c       = cancel(w_stable);
            assign w_new     = w_c & ~r_c_d;
            assign w_pri_c   = pri(w_c);
            assign w_pri_new = pri(w_new & ~r_arb.dir);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_c_d       <= 4'b0000;
                    r_mode_d    <= 2'b00;
                    r_arb.state <= ST_IDLE;
                    r_arb.dir   <= 4'b0000;
                    r_outdir    <= 4'b0000;
                    r_prev      <= 4'b0000;
                    r_changed   <= 1'b0;
                end else begin
                    r_c_d     <= w_c;
                    r_mode_d  <= w_mode;
                    r_prev    <= r_outdir;
                    r_changed <= (r_outdir != r_prev);

                    if (w_mode != r_mode_d) begin
                        // One blank clock on a mode switch; arbitration then
                        // restarts from the current c with nothing counted new.
                        r_arb.state <= ST_IDLE;
                        r_arb.dir   <= 4'b0000;
                        r_outdir    <= 4'b0000;
                    end else begin
                        case (w_mode)
                            MODE_PASS: begin
                                r_arb.state <= ST_IDLE;
                                r_arb.dir   <= 4'b0000;
                                r_outdir    <= w_stable;
                            end
                            MODE_8WAY: begin
                                r_arb.state <= ST_IDLE;
                                r_arb.dir   <= 4'b0000;
                                r_outdir    <= w_c;
                            end
                            MODE_LAST, MODE_STICKY: begin
                                case (r_arb.state)
                                    ST_IDLE: begin
                                        if (w_c != 4'b0000) begin
                                            r_arb.state <= ST_LOCKED;
                                            r_arb.dir   <= w_pri_c;
                                            r_outdir    <= w_pri_c;
                                        end else begin
                                            r_outdir    <= 4'b0000;
                                        end
                                    end
                                    ST_LOCKED: begin
                                        // Release of the held direction wins over
                                        // a new press arriving in the same clock.
                                        if ((w_c & r_arb.dir) == 4'b0000) begin
                                            if (w_c != 4'b0000) begin
                                                r_arb.dir <= w_pri_c;
                                                r_outdir  <= w_pri_c;
                                            end else begin
                                                r_arb.state <= ST_IDLE;
                                                r_arb.dir   <= 4'b0000;
                                                r_outdir    <= 4'b0000;
                                            end
                                        end else if (w_mode == MODE_LAST &&
                                                     (w_new & ~r_arb.dir) != 4'b0000) begin
                                            r_arb.dir <= w_pri_new;
                                            r_outdir  <= w_pri_new;
                                        end else begin
                                            r_outdir <= r_arb.dir;
                                        end
                                    end
                                    default: begin
                                        r_arb.state <= ST_IDLE;
                                        r_arb.dir   <= 4'b0000;
                                        r_outdir    <= 4'b0000;
                                    end
                                endcase
                            end
                            default: begin
                                r_arb.state <= ST_IDLE;
                                r_arb.dir   <= 4'b0000;
                                r_outdir    <= 4'b0000;
                            end
                        endcase
                    end
                end
            end

            assign outdir[4*gi +: 4] = r_outdir;
            assign changed[gi]       = r_changed;
        end
    endgenerate

endmodule
